// File: rtl/mips_defs.sv
// Shared definitions for the M/W load data path: load-kind encodings and the
// default byte-address width.
package mips_defs;

   localparam int ADDR_W = 32;

   // Load kinds carried on ld_type_M; codes 6 and 7 are unused and behave as LD_NONE.
   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LW   = 3'd1,
      LD_LH   = 3'd2,
      LD_LHU  = 3'd3,
      LD_LB   = 3'd4,
      LD_LBU  = 3'd5
   } ld_type_e;

   // Even parity over a word, available to any stage that protects its payload.
   function automatic logic parity32(input logic [31:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and zero/sign extension of a raw memory word.
// Also reports whether the access is misaligned for its load kind and whether
// the code is a real load at all.
module load_extend
   import mips_defs::*;
(
   input  logic [2:0]  i_ld_type,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data,
   output logic        o_misalign,
   output logic        o_is_load
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte lane (little-endian: lane k sits at bits 8k+7:8k).
   always_comb begin
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
   end

   // Pick the addressed halfword lane; addr[0] only matters for the alignment test.
   always_comb begin
      w_half = 16'h0000;
      if (i_addr_lo[1]) begin
         w_half = i_rdata[31:16];
      end else begin
         w_half = i_rdata[15:0];
      end
   end

   // Extend the selected lane per load kind; a misaligned access yields zero data.
   always_comb begin
      o_data     = 32'h0000_0000;
      o_misalign = 1'b0;
      o_is_load  = 1'b0;
      case (i_ld_type)
         LD_LW: begin
            o_is_load  = 1'b1;
            o_misalign = (i_addr_lo != 2'b00);
            if (o_misalign) begin
               o_data = 32'h0000_0000;
            end else begin
               o_data = i_rdata;
            end
         end
         LD_LH: begin
            o_is_load  = 1'b1;
            o_misalign = i_addr_lo[0];
            if (o_misalign) begin
               o_data = 32'h0000_0000;
            end else begin
               o_data = {{16{w_half[15]}}, w_half};
            end
         end
         LD_LHU: begin
            o_is_load  = 1'b1;
            o_misalign = i_addr_lo[0];
            if (o_misalign) begin
               o_data = 32'h0000_0000;
            end else begin
               o_data = {16'h0000, w_half};
            end
         end
         LD_LB: begin
            o_is_load = 1'b1;
            o_data    = {{24{w_byte[7]}}, w_byte};
         end
         LD_LBU: begin
            o_is_load = 1'b1;
            o_data    = {24'h00_0000, w_byte};
         end
         default: begin
            o_data     = 32'h0000_0000;
            o_misalign = 1'b0;
            o_is_load  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/load_mem_data.sv
// M/W pipeline boundary for loads: aligns and extends the memory word, flags
// misaligned loads (AdEL) and registers everything for GRF write-back.
// Every output comes straight from a register.
module load_mem_data
   import mips_defs::*;
#(
   parameter int ADDR_W = mips_defs::ADDR_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_M,
   input  logic [2:0]        ld_type_M,
   input  logic [ADDR_W-1:0] addr_M,
   input  logic [31:0]       m_data_rdata,
   input  logic [4:0]        rd_M,
   input  logic              stall_W,
   input  logic              flush_W,
   output logic [31:0]       ld_data_W,
   output logic [4:0]        rd_W,
   output logic              valid_W,
   output logic              wen_W,
   output logic              adel_W,
   output logic [ADDR_W-1:0] bad_vaddr_W
);

   logic [31:0]       w_ext_data;
   logic              w_misalign;
   logic              w_is_load;

   logic [31:0]       w_nxt_data;
   logic [4:0]        w_nxt_rd;
   logic              w_nxt_valid;
   logic              w_nxt_wen;
   logic              w_nxt_adel;
   logic [ADDR_W-1:0] w_nxt_bad;

   logic [31:0]       r_ld_data;
   logic [4:0]        r_rd;
   logic              r_valid;
   logic              r_wen;
   logic              r_adel;
   logic [ADDR_W-1:0] r_bad_vaddr;

   load_extend u_load_extend (
      .i_ld_type  (ld_type_M),
      .i_addr_lo  (addr_M[1:0]),
      .i_rdata    (m_data_rdata),
      .o_data     (w_ext_data),
      .o_misalign (w_misalign),
      .o_is_load  (w_is_load)
   );

   // Build the W-stage slot a capture would load; an invalid M slot becomes a bubble.
   always_comb begin
      w_nxt_data  = 32'h0000_0000;
      w_nxt_rd    = 5'd0;
      w_nxt_valid = 1'b0;
      w_nxt_wen   = 1'b0;
      w_nxt_adel  = 1'b0;
      w_nxt_bad   = {ADDR_W{1'b0}};
      if (valid_M) begin
         w_nxt_valid = 1'b1;
         w_nxt_rd    = rd_M;
         w_nxt_data  = w_ext_data;
         w_nxt_adel  = w_misalign;
         w_nxt_wen   = w_is_load & ~w_misalign & (rd_M != 5'd0);
         if (w_misalign) begin
            w_nxt_bad = addr_M;
         end else begin
            w_nxt_bad = {ADDR_W{1'b0}};
         end
      end else begin
         w_nxt_valid = 1'b0;
      end
   end

   // W registers: reset beats flush, flush beats stall, stall beats capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ld_data   <= 32'h0000_0000;
         r_rd        <= 5'd0;
         r_valid     <= 1'b0;
         r_wen       <= 1'b0;
         r_adel      <= 1'b0;
         r_bad_vaddr <= {ADDR_W{1'b0}};
      end else if (flush_W) begin
         r_ld_data   <= 32'h0000_0000;
         r_rd        <= 5'd0;
         r_valid     <= 1'b0;
         r_wen       <= 1'b0;
         r_adel      <= 1'b0;
         r_bad_vaddr <= {ADDR_W{1'b0}};
      end else if (!stall_W) begin
         r_ld_data   <= w_nxt_data;
         r_rd        <= w_nxt_rd;
         r_valid     <= w_nxt_valid;
         r_wen       <= w_nxt_wen;
         r_adel      <= w_nxt_adel;
         r_bad_vaddr <= w_nxt_bad;
      end else begin
         r_ld_data   <= r_ld_data;
         r_rd        <= r_rd;
         r_valid     <= r_valid;
         r_wen       <= r_wen;
         r_adel      <= r_adel;
         r_bad_vaddr <= r_bad_vaddr;
      end
   end

   assign ld_data_W   = r_ld_data;
   assign rd_W        = r_rd;
   assign valid_W     = r_valid;
   assign wen_W       = r_wen;
   assign adel_W      = r_adel;
   assign bad_vaddr_W = r_bad_vaddr;

endmodule

// File: tb/tb_load_mem_data.sv
// Self-checking bench for load_mem_data: a behavioural W-slot model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_load_mem_data;

   logic        clk;
   logic        reset;
   logic        valid_M;
   logic [2:0]  ld_type_M;
   logic [31:0] addr_M;
   logic [31:0] m_data_rdata;
   logic [4:0]  rd_M;
   logic        stall_W;
   logic        flush_W;
   logic [31:0] ld_data_W;
   logic [4:0]  rd_W;
   logic        valid_W;
   logic        wen_W;
   logic        adel_W;
   logic [31:0] bad_vaddr_W;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the W slot
   logic        known;
   logic [31:0] e_data;
   logic [4:0]  e_rd;
   logic        e_valid;
   logic        e_wen;
   logic        e_adel;
   logic [31:0] e_bad;

   load_mem_data #(.ADDR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_M      (valid_M),
      .ld_type_M    (ld_type_M),
      .addr_M       (addr_M),
      .m_data_rdata (m_data_rdata),
      .rd_M         (rd_M),
      .stall_W      (stall_W),
      .flush_W      (flush_W),
      .ld_data_W    (ld_data_W),
      .rd_W         (rd_W),
      .valid_W      (valid_W),
      .wen_W        (wen_W),
      .adel_W       (adel_W),
      .bad_vaddr_W  (bad_vaddr_W)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: the slot after this edge, from the rules on the M-stage inputs.
   always @(posedge clk) begin
      int unsigned kind;
      int unsigned off;
      int unsigned b;
      int unsigned h;
      logic        bad;
      if (!reset || flush_W) begin
         e_data = 0; e_rd = 0; e_valid = 0; e_wen = 0; e_adel = 0; e_bad = 0;
      end else if (stall_W) begin
         e_data = e_data;
      end else if (!valid_M) begin
         e_data = 0; e_rd = 0; e_valid = 0; e_wen = 0; e_adel = 0; e_bad = 0;
      end else begin
         kind = ld_type_M;
         if (kind > 5) kind = 0;
         off = addr_M % 4;
         b   = (m_data_rdata >> (8 * off)) % 256;
         h   = (m_data_rdata >> (16 * (off / 2))) % 65536;
         bad = (kind == 1 && off != 0) || ((kind == 2 || kind == 3) && (off % 2) != 0);
         e_valid = 1;
         e_rd    = rd_M;
         e_adel  = bad;
         e_bad   = bad ? addr_M : 32'd0;
         e_wen   = (kind != 0) && !bad && (rd_M != 0);
         if (bad || kind == 0)   e_data = 0;
         else if (kind == 1)     e_data = m_data_rdata;
         else if (kind == 2)     e_data = (h >= 32768) ? h + 32'hFFFF0000 : h;
         else if (kind == 3)     e_data = h;
         else if (kind == 4)     e_data = (b >= 128) ? b + 32'hFFFFFF00 : b;
         else                    e_data = b;
      end
      known = 1'b1;
   end

   // Compare process: DUT outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (known) begin
         chk("m_data",  ld_data_W,   e_data);
         chk("m_rd",    {27'd0, rd_W}, {27'd0, e_rd});
         chk("m_valid", {31'd0, valid_W}, {31'd0, e_valid});
         chk("m_wen",   {31'd0, wen_W},   {31'd0, e_wen});
         chk("m_adel",  {31'd0, adel_W},  {31'd0, e_adel});
         chk("m_bad",   bad_vaddr_W, e_bad);
      end
   end

   task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r,
                        input logic s, input logic f);
      valid_M = v; ld_type_M = t; addr_M = a; m_data_rdata = d; rd_M = r;
      stall_W = s; flush_W = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] LANES = 32'h80F17F02;

   initial begin
      known = 1'b0;
      e_data = 0; e_rd = 0; e_valid = 0; e_wen = 0; e_adel = 0; e_bad = 0;

      // Reset with random inputs for two cycles
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'b0, 1'b0);
         tick();
      end
      chk("rst_data",  ld_data_W, 32'h0);
      chk("rst_valid", {31'd0, valid_W}, 32'h0);
      chk("rst_bad",   bad_vaddr_W, 32'h0);

      reset = 1'b1;
      // Byte lanes, sign-extended
      drive(1, 3'd4, 32'h0000_0000, LANES, 5'd5, 0, 0); tick();
      chk("lb0", ld_data_W, 32'h0000_0002);
      chk("lb0_wen", {31'd0, wen_W}, 32'h1);
      drive(1, 3'd4, 32'h0000_0001, LANES, 5'd5, 0, 0); tick();
      chk("lb1", ld_data_W, 32'h0000_007F);
      drive(1, 3'd4, 32'h0000_0002, LANES, 5'd5, 0, 0); tick();
      chk("lb2", ld_data_W, 32'hFFFF_FFF1);
      drive(1, 3'd4, 32'h0000_0003, LANES, 5'd5, 0, 0); tick();
      chk("lb3", ld_data_W, 32'hFFFF_FF80);
      chk("lb3_adel", {31'd0, adel_W}, 32'h0);
      drive(1, 3'd5, 32'h0000_0003, LANES, 5'd6, 0, 0); tick();
      chk("lbu3", ld_data_W, 32'h0000_0080);
      drive(1, 3'd2, 32'h0000_0002, LANES, 5'd7, 0, 0); tick();
      chk("lh2", ld_data_W, 32'hFFFF_80F1);
      drive(1, 3'd3, 32'h0000_0000, LANES, 5'd7, 0, 0); tick();
      chk("lhu0", ld_data_W, 32'h0000_7F02);

      // Misalignment
      drive(1, 3'd1, 32'h0000_1002, LANES, 5'd8, 0, 0); tick();
      chk("lw_mis_adel", {31'd0, adel_W}, 32'h1);
      chk("lw_mis_bad",  bad_vaddr_W, 32'h0000_1002);
      chk("lw_mis_wen",  {31'd0, wen_W}, 32'h0);
      chk("lw_mis_data", ld_data_W, 32'h0);
      drive(1, 3'd2, 32'h0000_2001, LANES, 5'd8, 0, 0); tick();
      chk("lh_mis_adel", {31'd0, adel_W}, 32'h1);
      drive(1, 3'd4, 32'h0000_3003, LANES, 5'd8, 0, 0); tick();
      chk("lb_ok_adel", {31'd0, adel_W}, 32'h0);
      drive(0, 3'd1, 32'h0000_1002, LANES, 5'd8, 0, 0); tick();
      chk("inv_mis_adel", {31'd0, adel_W}, 32'h0);

      // Stall holds, stall+flush clears
      drive(1, 3'd1, 32'h0000_0100, 32'hDEADBEEF, 5'd9, 0, 0); tick();
      chk("lw_word", ld_data_W, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'd4, 32'h0000_0001 + i, 32'h1234_5678 + i, 5'd3, 1, 0); tick();
         chk("stall_hold", ld_data_W, 32'hDEADBEEF);
      end
      drive(1, 3'd1, 32'h0000_0200, 32'h5555_AAAA, 5'd4, 1, 1); tick();
      chk("flush_data",  ld_data_W, 32'h0);
      chk("flush_valid", {31'd0, valid_W}, 32'h0);

      // rd = 0, bubbles, non-load codes
      drive(1, 3'd1, 32'h0000_0010, 32'h0BAD_F00D, 5'd0, 0, 0); tick();
      chk("rd0_valid", {31'd0, valid_W}, 32'h1);
      chk("rd0_wen",   {31'd0, wen_W}, 32'h0);
      drive(0, 3'd1, 32'h0000_0010, 32'h0BAD_F00D, 5'd12, 0, 0); tick();
      chk("bubble_valid", {31'd0, valid_W}, 32'h0);
      chk("bubble_rd",    {27'd0, rd_W}, 32'h0);
      drive(1, 3'd0, 32'h0000_0003, LANES, 5'd13, 0, 0); tick();
      chk("none_rd",   {27'd0, rd_W}, 32'd13);
      chk("none_data", ld_data_W, 32'h0);
      drive(1, 3'd7, 32'h0000_0001, LANES, 5'd14, 0, 0); tick();
      chk("code7_wen",  {31'd0, wen_W}, 32'h0);
      chk("code7_adel", {31'd0, adel_W}, 32'h0);

      // Reset during a stall discards the held slot
      drive(1, 3'd1, 32'h0000_0020, 32'hCAFE_0001, 5'd15, 0, 0); tick();
      chk("pre_rst", ld_data_W, 32'hCAFE_0001);
      drive(1, 3'd1, 32'h0000_0020, 32'hCAFE_0002, 5'd15, 1, 0); tick();
      reset = 1'b0; tick();
      chk("midrst_data",  ld_data_W, 32'h0);
      chk("midrst_valid", {31'd0, valid_W}, 32'h0);
      reset = 1'b1;
      drive(0, 3'd0, 32'h0, 32'h0, 5'd0, 1, 0); tick();
      chk("post_rst", ld_data_W, 32'h0);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
